// File: rtl/pcm_boxcar_decim.sv
// Boxcar decimator: sums 2^DECIM_LOG2 signed PCM samples and emits their floor-average
// through a one-entry output register with a valid/ready handshake.
module pcm_boxcar_decim #(
  parameter int IN_W       = 32,
  parameter int DECIM_LOG2 = 3
) (
  input  logic            pclk,
  input  logic            preset,
  input  logic            start,
  input  logic            in_valid,
  input  logic [IN_W-1:0] in_pcm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IN_W-1:0] out_pcm,
  output logic            overrun,
  output logic [15:0]     out_count,
  output logic            state_dbg
);

  localparam int AW    = IN_W + DECIM_LOG2;
  localparam int CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << DECIM_LOG2) - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic signed [AW-1:0]   r_acc;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_out_valid;
  logic [IN_W-1:0]        r_out_pcm;
  logic                   r_overrun;
  logic [15:0]            r_out_count;

  logic signed [IN_W-1:0] w_in;
  logic signed [AW-1:0]   w_sum;
  logic [IN_W-1:0]        w_result;
  logic                   w_run;
  logic                   w_take;
  logic                   w_last;
  logic                   w_free;
  logic                   w_load;
  logic                   w_drop;

  always_ff @(posedge pclk) begin
    if (preset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = start ? S_ACCUM : S_IDLE;
      S_ACCUM: w_next = start ? S_ACCUM : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake: a word transfers on any edge where out_valid && out_ready; out_pcm is
  // stable while out_valid is high, and a new average may load in the same cycle a word drains.
  always_comb begin
    w_run  = (r_state == S_ACCUM) && start;
    w_take = w_run && in_valid;
    w_last = w_take && (r_cnt == CNT_MAX);
    w_free = !r_out_valid || out_ready;
    w_load = w_last && w_free;
    w_drop = w_last && !w_free;
  end

  // Accumulator carries DECIM_LOG2 guard bits so a full block of extremes cannot wrap.
  assign w_in     = in_pcm;
  assign w_sum    = r_acc + AW'(w_in);
  assign w_result = IN_W'(w_sum >>> DECIM_LOG2);

  always_ff @(posedge pclk) begin
    if (preset || !w_run) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_pcm   <= '0;
      r_overrun   <= 1'b0;
      if (preset) r_out_count <= '0;
    end else begin
      if (w_take) begin
        if (w_last) begin
          r_acc <= '0;
          r_cnt <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (w_load) begin
        r_out_pcm   <= w_result;
        r_out_valid <= 1'b1;
        r_out_count <= r_out_count + 16'd1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_drop) r_overrun <= 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_pcm   = r_out_pcm;
  assign overrun   = r_overrun;
  assign out_count = r_out_count;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_pcm_boxcar_decim.sv
// Bench for pcm_boxcar_decim: a floor-average model feeds an expected queue that is
// drained and compared whenever the DUT hands over an output word.
module tb_pcm_boxcar_decim;

  localparam int IN_W = 32;
  localparam int DL2  = 3;
  localparam int N    = 1 << DL2;

  logic            pclk = 1'b0;
  logic            preset;
  logic            start;
  logic            in_valid;
  logic [IN_W-1:0] in_pcm;
  logic            out_valid;
  logic            out_ready;
  logic [IN_W-1:0] out_pcm;
  logic            overrun;
  logic [15:0]     out_count;
  logic            state_dbg;

  logic [IN_W-1:0] exp_q[$];
  int     n_chk  = 0;
  int     n_pass = 0;
  longint m_acc  = 0;
  int     m_cnt  = 0;
  int     m_loads = 0;

  pcm_boxcar_decim #(.IN_W(IN_W), .DECIM_LOG2(DL2)) dut (
    .pclk(pclk), .preset(preset), .start(start), .in_valid(in_valid), .in_pcm(in_pcm),
    .out_valid(out_valid), .out_ready(out_ready), .out_pcm(out_pcm), .overrun(overrun),
    .out_count(out_count), .state_dbg(state_dbg)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [IN_W-1:0] got, input logic [IN_W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Any handshake seen between edges must match the oldest expected average.
  always @(negedge pclk) begin
    if (!preset && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_out", out_pcm, 32'hDEAD_BEEF ^ out_pcm);
      else                   check("avg", out_pcm, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic model_clear();
    m_acc = 0;
    m_cnt = 0;
  endtask

  // Drives one strobe; returns one cycle later, just after the accepting edge.
  task automatic send(input logic [IN_W-1:0] x);
    longint q;
    in_valid = 1'b1;
    in_pcm   = x;
    m_acc += longint'($signed(x));
    m_cnt++;
    if (m_cnt == N) begin
      q = m_acc / N;
      if (m_acc < 0 && (m_acc % N) != 0) q = q - 1;
      exp_q.push_back(q[IN_W-1:0]);
      m_loads++;
      model_clear();
    end
    tick();
    in_valid = 1'b0;
    in_pcm   = IN_W'($urandom);
  endtask

  task automatic send_n(input int n, input logic [IN_W-1:0] x);
    for (int i = 0; i < n; i++) send(x);
  endtask

  task automatic go();
    start = 1'b1;
    model_clear();
    tick();
  endtask

  task automatic stop();
    start = 1'b0;
    model_clear();
    tick();
  endtask

  task automatic wait_empty(input string tag);
    int k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      tick();
      k++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    preset = 1'b1; start = 1'b1; in_valid = 1'b1; in_pcm = IN_W'($urandom); out_ready = 1'b0;
    tick();
    in_pcm = IN_W'($urandom);
    tick();
    check("rst_valid", out_valid, 0);
    check("rst_pcm", out_pcm, 0);
    check("rst_overrun", overrun, 0);
    check("rst_count", out_count, 0);
    check("rst_state", state_dbg, 0);
    preset = 1'b0; start = 1'b0; in_valid = 1'b0;
    tick();

    // Basic block with latency check, then a sine stream.
    out_ready = 1'b1;
    go();
    check("state_accum", state_dbg, 1);
    send_n(7, 100);
    check("no_early_valid", out_valid, 0);
    send(100);
    check("latency_valid", out_valid, 1);
    check("latency_pcm", out_pcm, 100);
    check("count_1", out_count, 1);
    tick();
    check("valid_drops", out_valid, 0);
    for (int i = 0; i < 64; i++)
      send(IN_W'($rtoi(1.0e9 * $sin(2.0 * 3.14159265358979 * 1000.0 * i / 352800.0))));
    wait_empty("sine_drain");
    check("sine_count", out_count, 16'(m_loads));
    check("sine_overrun", overrun, 0);

    // Floor rounding and extremes.
    send(1); send_n(7, 0);
    send(32'hFFFF_FFFF); send_n(7, 0);
    send_n(N, 32'h7FFF_FFFF);
    send_n(N, 32'h8000_0000);
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < N; i++) send(IN_W'($urandom));
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < N; i++) send(IN_W'($signed($urandom_range(2000, 0)) - 1000));
    wait_empty("mix_drain");

    // Back-pressure: second block dropped while first is still held.
    out_ready = 1'b0;
    send_n(N, 10);
    check("bp_overrun_lo", overrun, 0);
    send_n(N, 20);
    void'(exp_q.pop_back());
    m_loads--;
    check("bp_overrun", overrun, 1);
    check("bp_hold_pcm", out_pcm, 10);
    check("bp_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_drained", out_valid, 0);
    check("bp_pcm_kept", out_pcm, 10);
    check("bp_q_empty", exp_q.size(), 0);
    check("bp_sticky", overrun, 1);

    // Load and drain on the same edge.
    stop();
    check("stop_clears_ovr", overrun, 0);
    go();
    send_n(N, 3);
    send_n(N - 1, 5);
    out_ready = 1'b1;
    send(5);
    check("ld_drain_valid", out_valid, 1);
    check("ld_drain_pcm", out_pcm, 5);
    check("ld_drain_ovr", overrun, 0);
    wait_empty("ld_drain_q");

    // Partial block discarded by a one-cycle stop.
    send_n(5, 7);
    stop();
    go();
    send_n(N, 10);
    check("partial_pcm", out_pcm, 10);
    check("partial_ovr", overrun, 0);
    wait_empty("partial_q");
    check("count_total", out_count, 16'(m_loads));

    // Mid-operation reset.
    out_ready = 1'b0;
    send_n(N, 55);
    void'(exp_q.pop_back());
    send_n(3, 1);
    preset = 1'b1;
    tick();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_count", out_count, 0);
    check("mid_rst_state", state_dbg, 0);
    preset = 1'b0;
    tick();
    go();
    out_ready = 1'b1;
    send_n(N, 4);
    wait_empty("post_rst_q");
    check("post_rst_count", out_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
